// File: rtl/input_sram_pkg.sv
// Shared types and constants for the input SRAM load controller.
package input_sram_pkg;

    localparam int PIX_W = 9;
    localparam int LANES = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        SETTLE,
        ISSUE,
        RUN,
        DONE
    } ld_state_t;

    // Bit offset of a lane inside a packed column word.
    function automatic int lane_lsb(input int lane, input int pix_w);
        return lane * pix_w;
    endfunction

endpackage

// File: rtl/input_pixel_packer.sv
// Collects LANES serial pixels into one staging word and flags it full until
// the controller consumes it.
module input_pixel_packer #(
    parameter int PIX_W = input_sram_pkg::PIX_W,
    parameter int LANES = input_sram_pkg::LANES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   consume,
    input  logic                   enable,
    input  logic                   pix_valid,
    input  logic [PIX_W-1:0]       pix_data,
    output logic                   pix_ready,
    output logic                   stage_full,
    output logic                   col_fetched,
    output logic [PIX_W*LANES-1:0] staging
);
    import input_sram_pkg::*;

    localparam int LC_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LC_W-1:0] lane_cnt;
    logic            take;

    assign pix_ready   = enable & ~stage_full;
    assign take        = pix_valid & pix_ready;
    assign col_fetched = take & (lane_cnt == LC_W'(LANES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt   <= '0;
            stage_full <= 1'b0;
            staging    <= '0;
        end else if (clear) begin
            lane_cnt   <= '0;
            stage_full <= 1'b0;
        end else begin
            if (take) begin
                for (int k = 0; k < LANES; k++) begin
                    if (lane_cnt == LC_W'(k))
                        staging[lane_lsb(k, PIX_W) +: PIX_W] <= pix_data;
                end
                lane_cnt <= col_fetched ? '0 : lane_cnt + LC_W'(1);
            end
            // A word can never complete while full, so set and clear never collide.
            if (col_fetched)
                stage_full <= 1'b1;
            else if (consume)
                stage_full <= 1'b0;
        end
    end

endmodule

// File: rtl/input_sram_load_ctrl.sv
// Frame sequencer: writes packed pixel columns into the input SRAM and hands
// each one to the MAC array, prefetching the next column meanwhile.
module input_sram_load_ctrl #(
    parameter  int PIX_W    = input_sram_pkg::PIX_W,
    parameter  int LANES    = input_sram_pkg::LANES,
    parameter  int NUM_COLS = 784,
    parameter  int SETTLE   = 1,
    localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   pix_valid,
    input  logic [PIX_W-1:0]       pix_data,
    output logic                   pix_ready,
    output logic                   sram_we,
    output logic [PIX_W*LANES-1:0] sram_data,
    output logic                   mac_start,
    input  logic                   mac_done,
    output logic [COL_W-1:0]       col_idx,
    output logic                   busy,
    output logic                   frame_done
);
    import input_sram_pkg::*;

    localparam int FC_W = $clog2(NUM_COLS + 1);
    localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    ld_state_t       state, state_nxt;
    logic [COL_W-1:0] col_nxt;
    logic [FC_W-1:0] fetch_cnt;
    logic [ST_W-1:0] settle_cnt, settle_nxt;
    logic            busy_nxt;
    logic            clear;
    logic            stage_full;
    logic            col_fetched;
    logic            fetch_open;

    // Stop fetching once every column of the frame has been staged.
    assign fetch_open = busy & (fetch_cnt < FC_W'(NUM_COLS));

    input_pixel_packer #(
        .PIX_W (PIX_W),
        .LANES (LANES)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .consume     (sram_we),
        .enable      (fetch_open),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .stage_full  (stage_full),
        .col_fetched (col_fetched),
        .staging     (sram_data)
    );

    always_comb begin
        state_nxt  = state;
        col_nxt    = col_idx;
        settle_nxt = settle_cnt;
        busy_nxt   = busy;
        clear      = 1'b0;
        sram_we    = 1'b0;
        mac_start  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    busy_nxt  = 1'b1;
                    col_nxt   = '0;
                    clear     = 1'b1;
                end
            end
            LOAD: begin
                if (stage_full)
                    state_nxt = WRITE;
            end
            WRITE: begin
                sram_we    = 1'b1;
                settle_nxt = '0;
                state_nxt  = (SETTLE == 0) ? ISSUE : input_sram_pkg::SETTLE;
            end
            input_sram_pkg::SETTLE: begin
                if (settle_cnt == ST_W'(SETTLE - 1))
                    state_nxt = ISSUE;
                else
                    settle_nxt = settle_cnt + ST_W'(1);
            end
            ISSUE: begin
                mac_start = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (mac_done) begin
                    if (col_idx == COL_W'(NUM_COLS - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                        col_nxt   = col_idx + COL_W'(1);
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col_idx    <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            col_idx    <= col_nxt;
            settle_cnt <= settle_nxt;
            busy       <= busy_nxt;
            if (clear)
                fetch_cnt <= '0;
            else if (col_fetched)
                fetch_cnt <= fetch_cnt + FC_W'(1);
        end
    end

endmodule
